pc_ctrl: RTL and testbench
==========================

PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 SHALL have port clk  in  1  system clock; all controller state updates on rising edge.
REQ-002 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port cmd_valid  in  1  command request from decoder.
REQ-004 SHALL have port cmd_op  in  3  0 HOLD, 1 STEP, 2 JMP, 3 BRANCH, 4 VECTOR; 5-7 treated as HOLD.
REQ-005 SHALL have port cmd_ready  out  1  high in IDLE; command accepted when cmd_valid && cmd_ready.
REQ-006 SHALL have port vec_sel  in  2  0 RESET FFFC, 1 NMI FFFA, 2 IRQ FFFE, 3 treated as IRQ; sampled at acceptance.
REQ-007 SHALL have port br_taken  in  1  branch condition; sampled at acceptance.
REQ-008 SHALL have port data_in  in  8  operand byte from bus; valid when data_valid high.
REQ-009 SHALL have port data_valid  in  1  operand byte strobe.
REQ-010 SHALL have port pcl_q, pch_q  in  8 each  current PC low and high bytes.
REQ-011 SHALL have port pcl_cout  in  1  carry out of PC low byte.
REQ-012 SHALL have port pcl_cin, pch_cin  out  1 each  increment enables for low and high bytes.
REQ-013 SHALL have port pcl_data, pch_data  out  8 each  load values for low and high bytes.
REQ-014 SHALL have port pcl_latch, pch_latch, pcl_update, pch_update  out  1 each  load strobes.
REQ-015 SHALL have port vec_addr  out  16  vector byte address to fetch; vec_req  out  1  fetch request.

Function
REQ-016 SHALL implement states IDLE, OP_LO, OP_HI, LOAD, FIX, VEC_LO, VEC_HI.
REQ-017 SHALL drive pcl_cin=1 only in STEP, and SHALL drive pch_cin = pcl_cin & pcl_cout combinationally; otherwise both 0.
REQ-018 STEP SHALL be single-cycle from IDLE; state remains IDLE; back-to-back STEPs SHALL increment every cycle.
REQ-019 JMP: IDLE -> OP_LO; on data_valid capture low byte -> OP_HI; on data_valid capture high byte -> LOAD.
REQ-020 LOAD SHALL last one cycle with latch and update strobes high for both bytes, then -> IDLE.
REQ-021 pcl_data/pch_data SHALL be registered, stable from the cycle before LOAD through the end of LOAD.
REQ-022 BRANCH with br_taken=0 SHALL behave as STEP; with br_taken=1 -> OP_LO and wait for offset byte.
REQ-023 Offset SHALL be signed 8-bit; sum = {pch_q,pcl_q} + sign-extended offset, modulo 2^16; wrap FFFF->0000 required.
REQ-024 VECTOR: vec_req high in VEC_LO with vec_addr = base, in VEC_HI with vec_addr = base+1; advance on data_valid; then LOAD.
REQ-025 Outside OP/VEC states data_valid SHALL be ignored; cmd_valid outside IDLE SHALL be ignored.
REQ-026 All strobes SHALL be single-cycle pulses, registered, deasserted in every state not named above.

Reset
REQ-027 On rst_n low: state IDLE, all strobes 0, pcl_cin/pch_cin 0, pcl_data/pch_data 00, vec_req 0, vec_addr 0000, cmd_ready 0.
REQ-028 Reset mid-sequence SHALL abort without any LOAD strobe; first cycle after release cmd_ready=1.

Configuration
REQ-029 Macro PC_CTRL_PAGE_PENALTY_EN defined: taken branch crossing a page SHALL load low byte only (pcl strobes) in LOAD, then one FIX cycle loading corrected high byte (pch strobes), then IDLE.
REQ-030 Macro PC_CTRL_PAGE_PENALTY_EN undefined: taken branch SHALL load both bytes in one LOAD cycle, never entering FIX.
REQ-031 Branch not crossing a page SHALL load both bytes in LOAD in either configuration.

Verification
REQ-032 Reset then 3 STEPs from PC 00FE -> pcl_cin high 3 cycles, pch_cin high only while pcl_q=FF; PC ends 0101.
REQ-033 JMP, data 34 then 12 -> LOAD pulse with pcl_data=34, pch_data=12; cmd_ready low 3 cycles.
REQ-034 BRANCH taken, PC 10F0, offset 20 -> target 1110; penalty build: LOAD pcl=10, FIX pch=11; no-penalty build: single LOAD 1110.
REQ-035 BRANCH taken, PC 0005, offset F0 -> target FFF5 (wrap); BRANCH not taken -> single STEP.
REQ-036 VECTOR vec_sel=0, data 00 then C0 -> vec_addr FFFC then FFFD, LOAD 00/C0.
REQ-037 rst_n low during OP_HI of JMP -> no latch/update pulses, outputs at reset values, next JMP completes normally.

Source files
------------

// File: rtl/pc_ctrl.sv
// Program-counter load/increment sequencer: steps, jumps, relative branches and vector fetches.
// Optional build macro PC_CTRL_PAGE_PENALTY_EN splits page-crossing branch loads into LOAD + FIX.
module pc_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    input  logic [2:0]  cmd_op,
    output logic        cmd_ready,
    input  logic [1:0]  vec_sel,
    input  logic        br_taken,
    input  logic [7:0]  data_in,
    input  logic        data_valid,
    input  logic [7:0]  pcl_q,
    input  logic [7:0]  pch_q,
    input  logic        pcl_cout,
    output logic        pcl_cin,
    output logic        pch_cin,
    output logic [7:0]  pcl_data,
    output logic [7:0]  pch_data,
    output logic        pcl_latch,
    output logic        pch_latch,
    output logic        pcl_update,
    output logic        pch_update,
    output logic [15:0] vec_addr,
    output logic        vec_req
);

    localparam logic [2:0] OP_STEP   = 3'd1;
    localparam logic [2:0] OP_JMP    = 3'd2;
    localparam logic [2:0] OP_BRANCH = 3'd3;
    localparam logic [2:0] OP_VECTOR = 3'd4;

`ifdef PC_CTRL_PAGE_PENALTY_EN
    localparam bit P_PAGE_PENALTY = 1'b1;
`else
    localparam bit P_PAGE_PENALTY = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_OP_LO, S_OP_HI, S_LOAD, S_FIX, S_VEC_LO, S_VEC_HI
    } state_t;

    state_t      r_state;
    logic        r_cmd_ready;
    logic        r_is_br;
    logic        r_fix;
    logic        r_pcl_ld;
    logic        r_pch_ld;
    logic [7:0]  r_pcl_data;
    logic [7:0]  r_pch_data;
    logic [15:0] r_vec_base;
    logic [15:0] r_vec_addr;
    logic        r_vec_req;

    logic        w_accept;
    logic        w_step;
    logic [15:0] w_vec_base;
    logic [15:0] w_br_sum;
    logic        w_cross;

    assign w_accept = cmd_valid && r_cmd_ready && (r_state == S_IDLE);
    assign w_step   = w_accept && ((cmd_op == OP_STEP) || ((cmd_op == OP_BRANCH) && !br_taken));
    assign w_br_sum = {pch_q, pcl_q} + {{8{data_in[7]}}, data_in};
    assign w_cross  = (w_br_sum[15:8] != pch_q);

    always_comb begin
        case (vec_sel)
            2'd0:    w_vec_base = 16'hFFFC;
            2'd1:    w_vec_base = 16'hFFFA;
            default: w_vec_base = 16'hFFFE;
        endcase
    end

    // Increment path is combinational so back-to-back STEPs advance the PC every cycle.
    assign pcl_cin = w_step;
    assign pch_cin = w_step & pcl_cout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b0;
            r_is_br     <= 1'b0;
            r_fix       <= 1'b0;
            r_pcl_ld    <= 1'b0;
            r_pch_ld    <= 1'b0;
            r_pcl_data  <= 8'h00;
            r_pch_data  <= 8'h00;
            r_vec_base  <= 16'h0000;
            r_vec_addr  <= 16'h0000;
            r_vec_req   <= 1'b0;
        end else begin
            r_pcl_ld   <= 1'b0;
            r_pch_ld   <= 1'b0;
            r_vec_req  <= 1'b0;
            r_vec_addr <= 16'h0000;
            case (r_state)
                S_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (w_accept) begin
                        case (cmd_op)
                            OP_JMP: begin
                                r_state     <= S_OP_LO;
                                r_is_br     <= 1'b0;
                                r_cmd_ready <= 1'b0;
                            end
                            OP_BRANCH: begin
                                if (br_taken) begin
                                    r_state     <= S_OP_LO;
                                    r_is_br     <= 1'b1;
                                    r_cmd_ready <= 1'b0;
                                end
                            end
                            OP_VECTOR: begin
                                r_state     <= S_VEC_LO;
                                r_vec_base  <= w_vec_base;
                                r_vec_addr  <= w_vec_base;
                                r_vec_req   <= 1'b1;
                                r_cmd_ready <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                S_OP_LO: begin
                    if (data_valid) begin
                        if (r_is_br) begin
                            // Branch target computed from the PC held steady since acceptance.
                            r_pcl_data <= w_br_sum[7:0];
                            r_pch_data <= w_br_sum[15:8];
                            r_pcl_ld   <= 1'b1;
                            r_pch_ld   <= !(P_PAGE_PENALTY && w_cross);
                            r_fix      <= P_PAGE_PENALTY && w_cross;
                            r_state    <= S_LOAD;
                        end else begin
                            r_pcl_data <= data_in;
                            r_state    <= S_OP_HI;
                        end
                    end
                end
                S_OP_HI: begin
                    if (data_valid) begin
                        r_pch_data <= data_in;
                        r_pcl_ld   <= 1'b1;
                        r_pch_ld   <= 1'b1;
                        r_fix      <= 1'b0;
                        r_state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (r_fix) begin
                        r_pch_ld <= 1'b1;
                        r_fix    <= 1'b0;
                        r_state  <= S_FIX;
                    end else begin
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                S_FIX: begin
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                S_VEC_LO: begin
                    r_vec_req  <= 1'b1;
                    r_vec_addr <= r_vec_base;
                    if (data_valid) begin
                        r_pcl_data <= data_in;
                        r_vec_addr <= r_vec_base + 16'd1;
                        r_state    <= S_VEC_HI;
                    end
                end
                S_VEC_HI: begin
                    r_vec_req  <= 1'b1;
                    r_vec_addr <= r_vec_base + 16'd1;
                    if (data_valid) begin
                        r_pch_data <= data_in;
                        r_vec_req  <= 1'b0;
                        r_vec_addr <= 16'h0000;
                        r_pcl_ld   <= 1'b1;
                        r_pch_ld   <= 1'b1;
                        r_fix      <= 1'b0;
                        r_state    <= S_LOAD;
                    end
                end
                default: begin
                    r_cmd_ready <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready  = r_cmd_ready;
    assign pcl_data   = r_pcl_data;
    assign pch_data   = r_pch_data;
    assign pcl_latch  = r_pcl_ld;
    assign pcl_update = r_pcl_ld;
    assign pch_latch  = r_pch_ld;
    assign pch_update = r_pch_ld;
    assign vec_addr   = r_vec_addr;
    assign vec_req    = r_vec_req;

endmodule

// File: tb/tb_pc_ctrl.sv
// Randomized bench for pc_ctrl: an external PC register plus a command-level model of the expected PC.
module tb_pc_ctrl;

`ifdef PC_CTRL_PAGE_PENALTY_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic [2:0]  cmd_op;
    logic        cmd_ready;
    logic [1:0]  vec_sel;
    logic        br_taken;
    logic [7:0]  data_in;
    logic        data_valid;
    logic        pcl_cout;
    logic        pcl_cin, pch_cin;
    logic [7:0]  pcl_data, pch_data;
    logic        pcl_latch, pch_latch, pcl_update, pch_update;
    logic [15:0] vec_addr;
    logic        vec_req;

    logic [15:0] r_pc = 16'h0000;
    logic        pc_set = 1'b0;
    logic [15:0] pc_set_val = 16'h0000;

    int n_checks = 0;
    int n_errors = 0;
    int n_lo = 0, n_hi = 0, n_busy = 0;

    always #5 clk = ~clk;

    pc_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
        .vec_sel(vec_sel), .br_taken(br_taken), .data_in(data_in), .data_valid(data_valid),
        .pcl_q(r_pc[7:0]), .pch_q(r_pc[15:8]), .pcl_cout(pcl_cout),
        .pcl_cin(pcl_cin), .pch_cin(pch_cin), .pcl_data(pcl_data), .pch_data(pch_data),
        .pcl_latch(pcl_latch), .pch_latch(pch_latch), .pcl_update(pcl_update), .pch_update(pch_update),
        .vec_addr(vec_addr), .vec_req(vec_req)
    );

    assign pcl_cout = (r_pc[7:0] == 8'hFF);

    // External PC byte registers driven by the controller's strobes.
    always @(posedge clk) begin
        if (pc_set) r_pc <= pc_set_val;
        else begin
            if (pcl_latch && pcl_update) r_pc[7:0] <= pcl_data;
            else if (pcl_cin)            r_pc[7:0] <= r_pc[7:0] + 8'd1;
            if (pch_latch && pch_update) r_pc[15:8] <= pch_data;
            else if (pch_cin)            r_pc[15:8] <= r_pc[15:8] + 8'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (pcl_latch) n_lo++;
            if (pch_latch) n_hi++;
            if (!cmd_ready) n_busy++;
            chk("lo_strobe_pair", {31'd0, pcl_update}, {31'd0, pcl_latch});
            chk("hi_strobe_pair", {31'd0, pch_update}, {31'd0, pch_latch});
            chk("pch_cin_carry", {31'd0, pch_cin}, {31'd0, pcl_cin && (r_pc[7:0] == 8'hFF)});
        end
    end

    task automatic set_pc(input logic [15:0] v);
        @(negedge clk);
        pc_set = 1'b1;
        pc_set_val = v;
        @(posedge clk);
        #1 pc_set = 1'b0;
    endtask

    task automatic do_cmd(input logic [2:0] op, input logic [1:0] vs, input logic br,
                          input logic [7:0] b0, input logic [7:0] b1, input int max_wait);
        logic [15:0] pc0, exp_pc, base;
        int nbytes, waits, k, w, lo0, hi0, exp_busy;
        bit step, fix, is_vec;
        nbytes = 0; waits = 0; step = 0; fix = 0; is_vec = 0;
        @(negedge clk);
        k = 0;
        while (!cmd_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
        pc0 = r_pc;
        exp_pc = pc0;
        base = (vs == 2'd0) ? 16'hFFFC : (vs == 2'd1) ? 16'hFFFA : 16'hFFFE;
        case (op)
            3'd1: step = 1;
            3'd2: begin nbytes = 2; exp_pc = {b1, b0}; end
            3'd3: begin
                if (br) begin
                    nbytes = 1;
                    exp_pc = 16'((int'(pc0) + int'($signed(b0))) & 32'hFFFF);
                    fix = PEN && (exp_pc[15:8] != pc0[15:8]);
                end else step = 1;
            end
            3'd4: begin nbytes = 2; exp_pc = {b1, b0}; is_vec = 1; end
            default: ;
        endcase
        if (step) exp_pc = pc0 + 16'd1;
        cmd_valid = 1'b1; cmd_op = op; vec_sel = vs; br_taken = br;
        data_valid = 1'($urandom); data_in = 8'($urandom);
        #1;
        chk("pcl_cin_accept", {31'd0, pcl_cin}, {31'd0, step});
        lo0 = n_lo; hi0 = n_hi; n_busy = 0;
        @(posedge clk);
        #1 cmd_valid = 1'b0; data_valid = 1'b0;
        for (int i = 0; i < nbytes; i++) begin
            w = $urandom_range(max_wait, 0);
            waits += w + 1;
            for (int j = 0; j <= w; j++) begin
                data_valid = (j == w);
                data_in = (j == w) ? ((i == 0) ? b0 : b1) : 8'($urandom);
                @(negedge clk);
                if (is_vec) begin
                    chk("vec_req_busy", {31'd0, vec_req}, 32'd1);
                    chk("vec_addr", {16'd0, vec_addr}, {16'd0, base + 16'(i)});
                end
                @(posedge clk);
                #1;
            end
        end
        data_valid = 1'b0;
        @(negedge clk);
        k = 0;
        while (!cmd_ready && k < 8) begin
            @(negedge clk);
            k++;
        end
        exp_busy = waits + ((nbytes > 0) ? 1 : 0) + (fix ? 1 : 0);
        chk("ready_after_cmd", {31'd0, cmd_ready}, 32'd1);
        chk("pc_result", {16'd0, r_pc}, {16'd0, exp_pc});
        chk("busy_cycles", n_busy, exp_busy);
        chk("lo_loads", n_lo - lo0, (nbytes > 0) ? 1 : 0);
        chk("hi_loads", n_hi - hi0, (nbytes > 0) ? 1 : 0);
        chk("vec_req_idle", {31'd0, vec_req}, 32'd0);
    endtask

    initial begin
        int lo0;
        logic [15:0] m;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; vec_sel = 2'd0;
        br_taken = 1'b0; data_in = 8'h00; data_valid = 1'b0;
        #1;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_strobes", {28'd0, pcl_latch, pch_latch, pcl_update, pch_update}, 32'd0);
        chk("rst_cin", {30'd0, pcl_cin, pch_cin}, 32'd0);
        chk("rst_data", {16'd0, pch_data, pcl_data}, 32'd0);
        chk("rst_vec", {15'd0, vec_req, vec_addr}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, cmd_ready}, 32'd1);

        // Three back-to-back STEPs across the low-byte carry.
        set_pc(16'h00FE);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd1;
        m = 16'h00FE;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("step_pcl_cin", {31'd0, pcl_cin}, 32'd1);
            chk("step_pch_cin", {31'd0, pch_cin}, {31'd0, m[7:0] == 8'hFF});
            m = m + 16'd1;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        chk("step_pc", {16'd0, r_pc}, 32'h0101);

        do_cmd(3'd2, 2'd0, 1'b0, 8'h34, 8'h12, 0);
        chk("jmp_pcl_data", {24'd0, pcl_data}, 32'h34);
        chk("jmp_pch_data", {24'd0, pch_data}, 32'h12);
        set_pc(16'h10F0);
        do_cmd(3'd3, 2'd0, 1'b1, 8'h20, 8'h00, 0);
        set_pc(16'h0005);
        do_cmd(3'd3, 2'd0, 1'b1, 8'hF0, 8'h00, 0);
        do_cmd(3'd3, 2'd0, 1'b0, 8'h55, 8'h00, 0);
        do_cmd(3'd4, 2'd0, 1'b0, 8'h00, 8'hC0, 0);
        do_cmd(3'd4, 2'd3, 1'b0, 8'h11, 8'h22, 2);
        do_cmd(3'd6, 2'd0, 1'b1, 8'h11, 8'h22, 0);

        // Reset while waiting for the high byte of a JMP.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd2;
        @(posedge clk);
        #1 cmd_valid = 1'b0; data_valid = 1'b1; data_in = 8'hAB;
        @(posedge clk);
        #1 data_valid = 1'b0;
        lo0 = n_lo;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_strobes", {28'd0, pcl_latch, pch_latch, pcl_update, pch_update}, 32'd0);
        chk("abort_data", {16'd0, pch_data, pcl_data}, 32'd0);
        chk("abort_ready", {31'd0, cmd_ready}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready_after", {31'd0, cmd_ready}, 32'd1);
        chk("abort_no_load", n_lo - lo0, 0);
        do_cmd(3'd2, 2'd0, 1'b0, 8'h78, 8'h56, 1);

        for (int t = 0; t < 250; t++) begin
            if ($urandom_range(7, 0) == 0) set_pc(16'($urandom));
            do_cmd(3'($urandom_range(7, 0)), 2'($urandom), 1'($urandom),
                   8'($urandom), 8'($urandom), 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
